sevseg_mux: RTL and testbench

// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/sevseg_mux.sv | 162 ++++++++++++++++
 tb/tb_sevseg_mux.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sevseg_mux.sv
// Time-multiplexed driver for common-anode 7-segment digits on a shared segment bus.
// One digit is scanned per slot; each slot opens with a dead time with all anodes off.
// Inputs are snapshotted once per frame so a value never tears across a scan.
module sevseg_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 48000,
  parameter int unsigned DEAD_CYCLES  = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);

  localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIGIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sevseg_mux: NUM_DIGITS must be 1..8");
  end
  if (DIGIT_CYCLES < 2) begin : g_bad_digit_cycles
    $error("sevseg_mux: DIGIT_CYCLES must be >= 2");
  end
  if (DEAD_CYCLES >= DIGIT_CYCLES) begin : g_bad_dead_cycles
    $error("sevseg_mux: DEAD_CYCLES must be < DIGIT_CYCLES");
  end

  // Active-low glyphs, bit 0 = segment a .. bit 6 = segment g.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h7F;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q;
  logic [NUM_DIGITS-1:0]   shadow_blank_q;
  logic                    shadow_lz_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_tick_q;
  logic                    frame_end;

  assign frame_end = (cnt_q == CntLast) && (idx_q == IdxLast);

  // Slot counter and digit index next state; index advances when the slot counter wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame snapshot of display inputs; reset leaves every digit blanked for one dark frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits_q <= '0;
      shadow_blank_q  <= '1;
      shadow_lz_q     <= 1'b0;
    end else if (frame_end) begin
      shadow_digits_q <= digits;
      shadow_blank_q  <= blank;
      shadow_lz_q     <= lz_suppress;
    end
  end

  // Decode the current slot into segment and anode drive, dark unless every condition allows.
  always_comb begin
    logic [3:0] cur_nib;
    logic       cur_blank;
    logic       upper_zero;
    logic       suppressed;
    logic       in_dead;
    logic       dark;

    cur_nib    = '0;
    cur_blank  = 1'b1;
    upper_zero = 1'b1;
    seg_d      = 7'h7F;
    anode_d    = '1;

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = shadow_digits_q[4*i +: 4];
        cur_blank = shadow_blank_q[i];
      end
      // Leading zero: this digit and everything to its left are zero.
      if (int'(idx_q) <= i && shadow_digits_q[4*i +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end

    suppressed = shadow_lz_q && upper_zero && (idx_q != '0);
    in_dead    = 32'(cnt_q) < DEAD_CYCLES;
    dark       = !en || in_dead || cur_blank || suppressed;

    if (!dark) begin
      seg_d = glyph(cur_nib);
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        anode_d[i] = (idx_q != IdxW'(i));
      end
    end
  end

  // Registered outputs; frame_tick marks the cycle after each snapshot edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q        <= 7'h7F;
      anode_q      <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      anode_q      <= anode_d;
      frame_tick_q <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign anode      = anode_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_mux.sv
// Directed bench for sevseg_mux: a 4-digit instance (8-cycle slots, 2 dead cycles)
// and a 1-digit instance for the glyph sweep.
module tb_sevseg_mux;

  logic        clk = 1'b0;
  logic        reset, en, lz_suppress;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic        frame_tick;

  logic        r1, en1, lz1, blank1;
  logic [3:0]  digits1;
  logic [6:0]  seg1;
  logic        anode1, tick1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [27:0] S12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] S1111 = {4{7'h79}};
  localparam logic [27:0] S2222 = {4{7'h24}};

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  sevseg_mux #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .blank(blank),
    .lz_suppress(lz_suppress), .seg(seg), .anode(anode), .frame_tick(frame_tick)
  );

  sevseg_mux #(.NUM_DIGITS(1), .DIGIT_CYCLES(8), .DEAD_CYCLES(2)) dut1 (
    .clk(clk), .reset(r1), .en(en1), .digits(digits1), .blank(blank1),
    .lz_suppress(lz1), .seg(seg1), .anode(anode1), .frame_tick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the 32 output cycles of one frame; all outputs go dark from edge dark_from on.
  task automatic check_frame(input string tag, input logic [27:0] sg, input logic [3:0] lit,
                             input int dark_from);
    int         n;
    logic       dark;
    logic [6:0] es;
    logic [3:0] ea;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        n    = 8 * d + c + 1;
        dark = (c < 2) || !lit[d] || (n >= dark_from);
        es   = dark ? 7'h7F : sg[7*d +: 7];
        ea   = dark ? 4'hF : ~(4'b0001 << d);
        check($sformatf("%s d%0d c%0d seg", tag, d, c), {25'd0, seg}, {25'd0, es});
        check($sformatf("%s d%0d c%0d anode", tag, d, c), {28'd0, anode}, {28'd0, ea});
        check($sformatf("%s d%0d c%0d tick", tag, d, c), {31'd0, frame_tick},
              {31'd0, n == 32});
      end
    end
  endtask

  task automatic drive_later(input int n, input logic [15:0] d, input logic [3:0] b,
                             input logic lz, input logic e);
    repeat (n) @(posedge clk);
    #2;
    digits      = d;
    blank       = b;
    lz_suppress = lz;
    en          = e;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; lz_suppress = 1'b0; digits = 16'h12AF; blank = 4'h0;
    r1 = 1'b1; en1 = 1'b1; lz1 = 1'b0; blank1 = 1'b0; digits1 = 4'h0;

    repeat (3) step();
    check("reset seg", {25'd0, seg}, 32'h7F);
    check("reset anode", {28'd0, anode}, 32'hF);
    check("reset tick", {31'd0, frame_tick}, 32'h0);
    reset = 1'b0;

    check_frame("f0", 28'h0, 4'b0000, 33);
    fork
      check_frame("f1", S12AF, 4'hF, 33);
      drive_later(5, 16'h1111, 4'h0, 1'b0, 1'b1);
    join
    fork
      check_frame("f2", S1111, 4'hF, 33);
      drive_later(13, 16'h2222, 4'h0, 1'b0, 1'b1);
    join
    fork
      check_frame("f3", S2222, 4'hF, 33);
      drive_later(3, 16'h0030, 4'h0, 1'b1, 1'b1);
    join
    fork
      check_frame("f4", {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b0011, 33);
      drive_later(3, 16'h0000, 4'h0, 1'b1, 1'b1);
    join
    fork
      check_frame("f5", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 33);
      drive_later(3, 16'h12AF, 4'b0100, 1'b0, 1'b1);
    join
    check_frame("f6", S12AF, 4'b1011, 33);
    fork
      check_frame("f7", S12AF, 4'b1011, 13);
      drive_later(12, 16'h12AF, 4'b0100, 1'b0, 1'b0);
    join
    check_frame("f8", S12AF, 4'b1011, 1);
    en = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("f9 c%0d seg", k - 1), {25'd0, seg}, (k >= 3) ? 32'h0E : 32'h7F);
      check($sformatf("f9 c%0d anode", k - 1), {28'd0, anode}, (k >= 3) ? 32'hE : 32'hF);
    end
    reset = 1'b1;
    step();
    check("midreset seg", {25'd0, seg}, 32'h7F);
    check("midreset anode", {28'd0, anode}, 32'hF);
    check("midreset tick", {31'd0, frame_tick}, 32'h0);
    reset = 1'b0;
    check_frame("r0", 28'h0, 4'b0000, 33);
    check_frame("r1", S12AF, 4'b1011, 33);

    // Single-digit sweep of the glyph table, one value per frame.
    repeat (3) step();
    check("d1 reset seg", {25'd0, seg1}, 32'h7F);
    check("d1 reset anode", {31'd0, anode1}, 32'h1);
    r1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("d1 f0 c%0d seg", c), {25'd0, seg1}, 32'h7F);
      check($sformatf("d1 f0 c%0d tick", c), {31'd0, tick1}, {31'd0, c == 7});
    end
    for (int v = 0; v < 16; v++) begin
      digits1 = 4'(v + 1);
      for (int c = 0; c < 8; c++) begin
        step();
        check($sformatf("d1 v%0h c%0d seg", v, c), {25'd0, seg1},
              (c < 2) ? 32'h7F : {25'd0, glyph_tab[v]});
        check($sformatf("d1 v%0h c%0d anode", v, c), {31'd0, anode1},
              (c < 2) ? 32'h1 : 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
